int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
- Interrupt controller for the 8-bit pipelined CPU.
- Turns the external asynchronous int_sig into a controlled pipeline entry sequence: drain to a safe point, flush, save return PC, then force a vector fetch.
- Tracks ISR residency until an RTI retires.
- Sits between the CPU wrapper's int_sig pin and the fetch/hazard logic.

Parameters:
- VEC_ADDR, 8'h01: instruction-memory address whose contents are loaded as the ISR start PC.
- SYNC_STAGES, 2: number of synchronizer flops on int_sig; legal range 2..4.
- ADDR_W, 8: PC/address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- int_sig  in  1  external interrupt request, asynchronous, edge-triggered (rising).
- int_en  in  1  global interrupt enable from the CPU status logic.
- branch_in_flight  in  1  control transfer in EX/MEM; not a safe point.
- stall_in  in  1  pipeline stalled by the hazard unit; not a safe point.
- pc_next  in  ADDR_W  PC of the oldest not-yet-committed instruction (return address).
- save_ack  in  1  stack push of save_pc completed.
- rti_retire  in  1  RTI instruction reached writeback (1-cycle pulse).
- fetch_hold  out  1  freeze PC and IF stage.
- pipe_flush  out  1  squash IF/ID/EX contents.
- save_req  out  1  request push of save_pc to the stack.
- save_pc  out  ADDR_W  captured return address.
- vec_load  out  1  load PC from M[vec_addr].
- vec_addr  out  ADDR_W  constant VEC_ADDR.
- int_ack  out  1  1-cycle pulse when the interrupt is accepted.
- in_isr  out  1  CPU is executing the ISR.
- int_pending  out  1  latched, not-yet-serviced request.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Synchronizer, edge-detect previous bit, pending and save_pc are all cleared to 0.
  - All outputs are 0, except vec_addr, which is always VEC_ADDR.
- Synchronizer and edge detect:
  - int_sig passes through SYNC_STAGES flops; an edge is registered as sync_out & ~prev.
  - int_pending sets SYNC_STAGES+1 rising edges after the first edge that samples int_sig high.
  - Pulses shorter than one clk period may be lost; this is a documented restriction.
- Pending latch:
  - Set on an edge; cleared on the IDLE->WAIT_SAFE transition.
  - An edge in the same cycle as the clear wins, so pending stays 1.
  - Multiple edges while pending collapse into one request (one-deep).
- A held-high int_sig at reset release produces exactly one request, because prev resets to 0.
- FSM, Moore outputs decoded from registered state:
  - IDLE: all outputs 0. If int_pending && int_en, go to WAIT_SAFE.
  - WAIT_SAFE: fetch_hold=1. When !branch_in_flight && !stall_in, capture pc_next into save_pc and go to FLUSH. Otherwise stay; there is no timeout.
  - FLUSH: exactly 1 cycle, with pipe_flush=1 and fetch_hold=1. Then go to SAVE.
  - SAVE: save_req=1 and fetch_hold=1, held until save_ack. save_ack sampled in the first SAVE cycle means 1-cycle residency. Then go to VECTOR.
  - VECTOR: exactly 1 cycle, with vec_load=1, int_ack=1 and fetch_hold=1. Then go to ISR.
  - ISR: in_isr=1. On rti_retire, go to IDLE.
- Nesting:
  - No nesting. Edges during ISR latch pending but are serviced only after return to IDLE.
  - If rti_retire arrives with pending=1 and int_en=1, the FSM enters WAIT_SAFE on the cycle after reaching IDLE.
- int_en is only sampled in IDLE. Deasserting it after leaving IDLE does not abort the sequence.
- rti_retire outside ISR is ignored.
- save_ack outside SAVE is ignored.
- Minimum latency:
  - Accepted pending to vec_load: 4 cycles (WAIT_SAFE, FLUSH, SAVE, VECTOR) with no hazards and immediate save_ack.
  - Synchronization to vec_load: SYNC_STAGES+5 cycles.
- Reset mid-sequence: immediately returns to IDLE with all outputs 0. A partially issued save is abandoned; the stack logic must also be reset by rst.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (IDLE, WAIT_SAFE, FLUSH, SAVE, VECTOR, ISR, 3-bit encoding);
  - INT_VEC_ADDR default;
  - ADDR_W.
- One sub-module: int_sync_edge, which contains the SYNC_STAGES synchronizer, the rising-edge detector and the pending latch with its clear input.

Test Plan:
- Basic service: rst released, int_sig 0->1 at t0, no hazards, save_ack tied 1, pc_next=8'h23.
  - int_pending rises after 3 clk edges.
  - Then fetch_hold, a 1-cycle pipe_flush, a 1-cycle save_req with save_pc=8'h23, then vec_load and int_ack pulses with vec_addr=8'h01.
  - in_isr=1 until rti_retire, then in_isr=0.
- Safe-point wait: branch_in_flight=1 for 5 cycles after pending.
  - WAIT_SAFE is held 5 cycles with fetch_hold=1 and pipe_flush=0.
  - save_pc captures pc_next=8'h40 from the first cycle branch_in_flight=0.
- Masking: int_en=0 and edge arrives.
  - int_pending=1 and the FSM stays IDLE for 20 cycles.
  - Setting int_en=1 starts the sequence on the next edge.
- Back-to-back: a second int_sig edge during ISR.
  - int_pending=1 while in_isr=1.
  - rti_retire gives IDLE for 1 cycle, then WAIT_SAFE; exactly one extra int_ack is observed.
- Slow ack: save_ack delayed 3 cycles.
  - save_req=1 for 4 cycles; vec_load appears the cycle after save_ack.
- Reset mid-op: assert rst during SAVE.
  - All outputs 0 immediately (asynchronous); int_pending=0.
  - No vec_load after release unless a new edge arrives.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, interrupt vector location and the
// interrupt sequencer's state encoding plus its per-state control outputs.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] INT_VEC_ADDR = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAFE,
        FLUSH,
        SAVE,
        VECTOR,
        ISR
    } int_state_t;

    typedef struct packed {
        logic fetch_hold;
        logic pipe_flush;
        logic save_req;
        logic vec_load;
        logic int_ack;
        logic in_isr;
    } int_ctrl_t;

    // Moore decode: the control word each state presents to the pipeline.
    function automatic int_ctrl_t ctrl_for(input int_state_t s);
        int_ctrl_t c;
        c = '0;
        case (s)
            WAIT_SAFE: c.fetch_hold = 1'b1;
            FLUSH: begin
                c.fetch_hold = 1'b1;
                c.pipe_flush = 1'b1;
            end
            SAVE: begin
                c.fetch_hold = 1'b1;
                c.save_req   = 1'b1;
            end
            VECTOR: begin
                c.fetch_hold = 1'b1;
                c.vec_load   = 1'b1;
                c.int_ack    = 1'b1;
            end
            ISR:     c.in_isr = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Pipeline-facing signals of the interrupt sequencer; the sequencer uses the
// slave view, the CPU fetch/hazard logic the master view.
interface int_sequencer_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) ();
    logic              int_en;
    logic              branch_in_flight;
    logic              stall_in;
    logic [ADDR_W-1:0] pc_next;
    logic              save_ack;
    logic              rti_retire;

    logic              fetch_hold;
    logic              pipe_flush;
    logic              save_req;
    logic [ADDR_W-1:0] save_pc;
    logic              vec_load;
    logic [ADDR_W-1:0] vec_addr;
    logic              int_ack;
    logic              in_isr;
    logic              int_pending;

    modport slave (
        input  int_en, branch_in_flight, stall_in, pc_next, save_ack, rti_retire,
        output fetch_hold, pipe_flush, save_req, save_pc, vec_load, vec_addr,
               int_ack, in_isr, int_pending
    );

    modport master (
        output int_en, branch_in_flight, stall_in, pc_next, save_ack, rti_retire,
        input  fetch_hold, pipe_flush, save_req, save_pc, vec_load, vec_addr,
               int_ack, in_isr, int_pending
    );
endinterface

// File: rtl/int_sync_edge.sv
// Synchronizes the asynchronous interrupt pin (SYNC_STAGES in 2..4), detects
// its rising edge and holds a one-deep pending request until cleared.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic clear,
    output logic pending
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_seen;

    assign edge_seen = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value and the chain shifts one stage per clock.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            // A new edge beats a simultaneous clear; repeated edges collapse.
            pending <= edge_seen | (pending & ~clear);
        end
    end
endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: waits for a safe point, flushes, saves the return
// PC, forces the vector fetch and tracks ISR residency until RTI retires.
module int_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_ADDR    = ADDR_W'(INT_VEC_ADDR),
    parameter int                SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    input logic           int_sig,
    int_sequencer_if.slave bus
);
    int_state_t        state;
    int_ctrl_t         ctrl;
    logic [ADDR_W-1:0] save_pc_q;
    logic              pending;
    logic              accept;

    // int_en only matters here; once the sequence starts it runs to the ISR.
    assign accept = (state == IDLE) && pending && bus.int_en;

    int_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(int_sig),
        .clear   (accept),
        .pending (pending)
    );

    // Control word is registered together with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctrl      <= '0;
            save_pc_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= WAIT_SAFE;
                    ctrl  <= ctrl_for(WAIT_SAFE);
                end
                WAIT_SAFE: if (!bus.branch_in_flight && !bus.stall_in) begin
                    save_pc_q <= bus.pc_next;
                    state     <= FLUSH;
                    ctrl      <= ctrl_for(FLUSH);
                end
                FLUSH: begin
                    state <= SAVE;
                    ctrl  <= ctrl_for(SAVE);
                end
                SAVE: if (bus.save_ack) begin
                    state <= VECTOR;
                    ctrl  <= ctrl_for(VECTOR);
                end
                VECTOR: begin
                    state <= ISR;
                    ctrl  <= ctrl_for(ISR);
                end
                ISR: if (bus.rti_retire) begin
                    state <= IDLE;
                    ctrl  <= ctrl_for(IDLE);
                end
                default: begin
                    state <= IDLE;
                    ctrl  <= '0;
                end
            endcase
        end
    end

    assign bus.fetch_hold  = ctrl.fetch_hold;
    assign bus.pipe_flush  = ctrl.pipe_flush;
    assign bus.save_req    = ctrl.save_req;
    assign bus.vec_load    = ctrl.vec_load;
    assign bus.int_ack     = ctrl.int_ack;
    assign bus.in_isr      = ctrl.in_isr;
    assign bus.save_pc     = save_pc_q;
    assign bus.vec_addr    = VEC_ADDR;
    assign bus.int_pending = pending;
endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus randomized
// service sequences checked cycle by cycle against a phase-timeline model.
module tb_int_sequencer;

    typedef enum {P_IDLE, P_WAIT, P_FLUSH, P_SAVE, P_VEC, P_ISR} phase_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_sig;
    int         checks = 0;
    int         errors = 0;
    int         ack_count = 0;
    logic [7:0] exp_save_pc = 8'h00;

    int_sequencer_if bus ();

    int_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .int_sig(int_sig),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // {fetch_hold, pipe_flush, save_req, vec_load, int_ack, in_isr}
    function automatic logic [5:0] exp_ctrl(input phase_t p);
        case (p)
            P_WAIT:  return 6'b100000;
            P_FLUSH: return 6'b110000;
            P_SAVE:  return 6'b101000;
            P_VEC:   return 6'b100110;
            P_ISR:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] got_ctrl();
        return {bus.fetch_hold, bus.pipe_flush, bus.save_req,
                bus.vec_load, bus.int_ack, bus.in_isr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.int_en           = 1'b0;
        bus.branch_in_flight = 1'b0;
        bus.stall_in         = 1'b0;
        bus.pc_next          = 8'h00;
        bus.save_ack         = 1'b0;
        bus.rti_retire       = 1'b0;
    endtask

    // Raise int_sig from IDLE; pending must appear on exactly the third edge.
    task automatic raise_int(input bit keep_high);
        int_sig = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++;
            if (bus.int_pending !== (t == 3)) begin
                errors++;
                $display("FAIL raise_pending edge=%0d got %b exp %b", t, bus.int_pending, (t == 3));
            end
        end
        if (!keep_high) int_sig = 1'b0;
    endtask

    // Model of one full service starting in the IDLE cycle where pending=1.
    // h: cycles of hazard from this cycle; d: save_ack delay; isr_len: extra
    // ISR cycles before RTI; reraise: new int_sig edge at ISR entry.
    task automatic service(input int h, input int d, input int isr_len,
                           input logic [7:0] pc, input bit reraise, input string tag);
        int         w, k_vec, k_isr_last, total, raise_at, k;
        logic [1:0] hz;
        logic       exp_pend;
        phase_t     ph;
        w          = (h > 1) ? h : 1;
        k_vec      = w + 3 + d;
        k_isr_last = k_vec + 1 + isr_len;
        total      = k_isr_last + 1;
        raise_at   = reraise ? k_vec + 1 : total + 100;
        for (int c = 0; c < total; c++) begin
            bus.int_en = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (c >= raise_at) int_sig = 1'b1;
            if (c < h)       hz = 2'($urandom_range(1, 3));
            else if (c == w) hz = 2'b00;
            else             hz = 2'($urandom_range(0, 3));
            bus.branch_in_flight = hz[0];
            bus.stall_in         = hz[1];
            bus.pc_next = (c == w) ? pc : pc ^ 8'($urandom_range(1, 255));
            if (c == w + 2 + d)                 bus.save_ack = 1'b1;
            else if (c >= w + 2 && c < w + 2 + d) bus.save_ack = 1'b0;
            else                                bus.save_ack = 1'($urandom_range(0, 1));
            if (c == k_isr_last)  bus.rti_retire = 1'b1;
            else if (c > k_vec)   bus.rti_retire = 1'b0;
            else                  bus.rti_retire = 1'($urandom_range(0, 1));
            tick();
            k = c + 1;
            if (k <= w)               ph = P_WAIT;
            else if (k == w + 1)      ph = P_FLUSH;
            else if (k <= w + 2 + d)  ph = P_SAVE;
            else if (k == k_vec)      ph = P_VEC;
            else if (k <= k_isr_last) ph = P_ISR;
            else                      ph = P_IDLE;
            if (k == w + 1) exp_save_pc = pc;
            exp_pend = (k >= raise_at + 3);
            if (bus.int_ack === 1'b1) ack_count++;
            checks++;
            if (got_ctrl() !== exp_ctrl(ph)) begin
                errors++;
                $display("FAIL %s ctrl k=%0d got %b exp %b", tag, k, got_ctrl(), exp_ctrl(ph));
            end
            checks++;
            if (bus.save_pc !== exp_save_pc) begin
                errors++;
                $display("FAIL %s save_pc k=%0d got %h exp %h", tag, k, bus.save_pc, exp_save_pc);
            end
            checks++;
            if (bus.int_pending !== exp_pend) begin
                errors++;
                $display("FAIL %s pending k=%0d got %b exp %b", tag, k, bus.int_pending, exp_pend);
            end
            checks++;
            if (bus.vec_addr !== 8'h01) begin
                errors++;
                $display("FAIL %s vec_addr k=%0d got %h exp 01", tag, k, bus.vec_addr);
            end
        end
        quiet_inputs();
    endtask

    // Idle for n cycles with no new edge: nothing asserted, nothing pending.
    task automatic expect_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.int_en   = 1'($urandom_range(0, 1));
            bus.save_ack = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (got_ctrl() !== 6'b0 || bus.int_pending !== 1'b0) begin
                errors++;
                $display("FAIL %s idle cyc=%0d ctrl %b pending %b exp 000000 0", tag, i, got_ctrl(), bus.int_pending);
            end
        end
        quiet_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        int_sig = 1'b0;
        quiet_inputs();
        repeat (3) tick();
        checks++;
        if (got_ctrl() !== 6'b0 || bus.int_pending !== 1'b0 || bus.save_pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_state ctrl %b pending %b save_pc %h exp zeros", got_ctrl(), bus.int_pending, bus.save_pc);
        end
        checks++;
        if (bus.vec_addr !== 8'h01) begin
            errors++;
            $display("FAIL reset_vec_addr got %h exp 01", bus.vec_addr);
        end
        rst = 1'b0;
        exp_save_pc = 8'h00;
        expect_idle(4, "reset_release");
    endtask

    task automatic test_basic();
        raise_int(1'b0);
        service(0, 0, 2, 8'h23, 1'b0, "basic");
    endtask

    task automatic test_safe_point();
        raise_int(1'b0);
        service(5, 0, 1, 8'h40, 1'b0, "safe_point");
    endtask

    task automatic test_masking();
        bus.int_en = 1'b0;
        raise_int(1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.int_en = 1'b0;
            bus.save_ack = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (got_ctrl() !== 6'b0 || bus.int_pending !== 1'b1) begin
                errors++;
                $display("FAIL masking cyc=%0d ctrl %b pending %b exp 000000 1", i, got_ctrl(), bus.int_pending);
            end
        end
        service(0, 1, 1, 8'h77, 1'b0, "masking_release");
    endtask

    task automatic test_back_to_back();
        ack_count = 0;
        raise_int(1'b0);
        service(0, 1, 4, 8'h11, 1'b1, "b2b_first");
        service(1, 0, 2, 8'h12, 1'b0, "b2b_second");
        int_sig = 1'b0;
        expect_idle(6, "b2b_after");
        checks++;
        if (ack_count !== 2) begin
            errors++;
            $display("FAIL b2b_ack_count got %0d exp 2", ack_count);
        end
    endtask

    task automatic test_slow_ack();
        raise_int(1'b0);
        service(0, 3, 1, 8'h9C, 1'b0, "slow_ack");
    endtask

    task automatic test_reset_mid_op();
        raise_int(1'b0);
        bus.int_en  = 1'b1;
        bus.pc_next = 8'h5A;
        repeat (3) tick();
        checks++;
        if (bus.save_req !== 1'b1 || bus.save_pc !== 8'h5A) begin
            errors++;
            $display("FAIL mid_op_in_save save_req %b save_pc %h exp 1 5a", bus.save_req, bus.save_pc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got_ctrl() !== 6'b0 || bus.int_pending !== 1'b0 || bus.save_pc !== 8'h00) begin
            errors++;
            $display("FAIL mid_op_async ctrl %b pending %b save_pc %h exp zeros", got_ctrl(), bus.int_pending, bus.save_pc);
        end
        tick();
        rst = 1'b0;
        exp_save_pc = 8'h00;
        expect_idle(15, "mid_op_after");
    endtask

    task automatic test_held_high();
        int_sig = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_save_pc = 8'h00;
        raise_int(1'b1);
        service(2, 0, 1, 8'hE1, 1'b0, "held_high");
        expect_idle(10, "held_high_after");
        int_sig = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            raise_int(1'b0);
            service($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 5),
                    8'($urandom_range(0, 255)), 1'b0, "random");
        end
        expect_idle(3, "random_after");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_safe_point();
        test_masking();
        test_back_to_back();
        test_slow_ack();
        test_reset_mid_op();
        test_held_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
